// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared encodings and helpers for the divide sequencer
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_ITERS = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // ALU opcodes EX decodes into signed_div_i
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    function automatic logic div_is_signed(input logic [7:0] aluop);
        return aluop == EXE_DIV_OP;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic cond,
                                                    input logic [DIV_WIDTH-1:0] val);
        return cond ? (~val + DIV_WIDTH'(1)) : val;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division trial subtract on the partial remainder window
module div_step
    import div_seq_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH:0]   diff_o
);

    // bit 32 of the difference is the borrow: set means the trial failed
    always_comb begin
        diff_o = rem_i - {1'b0, divisor_i};
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - 32-iteration radix-2 restoring DIV/DIVU sequencer returning {remainder, quotient}
module div_seq
    import div_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   annul_i,
    input  logic                   signed_div_i,
    input  logic [DIV_WIDTH-1:0]   opdata1_i,
    input  logic [DIV_WIDTH-1:0]   opdata2_i,
    output logic [2*DIV_WIDTH-1:0] result_o,
    output logic                   ready_o,
    output logic                   stallreq_o
);

    div_state_e                 state_q;
    logic [DIV_CNT_W-1:0]       cnt_q;
    logic [2*DIV_WIDTH:0]       work_q;
    logic [DIV_WIDTH-1:0]       divisor_q;
    logic                       sign1_q;
    logic                       sign2_q;
    logic [2*DIV_WIDTH-1:0]     result_q;
    logic                       ready_q;

    logic                       op1_neg;
    logic                       op2_neg;
    logic [DIV_WIDTH-1:0]       op1_abs;
    logic [DIV_WIDTH-1:0]       op2_abs;
    logic [DIV_WIDTH:0]         diff_d;
    logic [2*DIV_WIDTH:0]       work_d;
    logic [DIV_WIDTH-1:0]       quot_fix;
    logic [DIV_WIDTH-1:0]       rem_fix;

    div_step u_step (
        .rem_i     (work_q[2*DIV_WIDTH:DIV_WIDTH]),
        .divisor_i (divisor_q),
        .diff_o    (diff_d)
    );

    // work_q holds {remainder window, dividend/quotient bits}; bit 0 receives each quotient bit
    always_comb begin
        op1_neg  = signed_div_i & opdata1_i[DIV_WIDTH-1];
        op2_neg  = signed_div_i & opdata2_i[DIV_WIDTH-1];
        op1_abs  = neg_if(op1_neg, opdata1_i);
        op2_abs  = neg_if(op2_neg, opdata2_i);
        if (diff_d[DIV_WIDTH]) begin
            work_d = {work_q[2*DIV_WIDTH-1:0], 1'b0};
        end else begin
            work_d = {diff_d[DIV_WIDTH-1:0], work_q[DIV_WIDTH-1:0], 1'b1};
        end
        quot_fix = neg_if(sign1_q ^ sign2_q, work_q[DIV_WIDTH-1:0]);
        rem_fix  = neg_if(sign1_q, work_q[2*DIV_WIDTH:DIV_WIDTH+1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        cnt_q     <= '0;
                        sign1_q   <= op1_neg;
                        sign2_q   <= op2_neg;
                        divisor_q <= op2_abs;
                        work_q    <= {{DIV_WIDTH{1'b0}}, op1_abs, 1'b0};
                        state_q   <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    result_q <= '0;
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                        ready_q <= DIV_RESULT_NOT_READY;
                    end else begin
                        state_q <= DIV_END;
                        ready_q <= DIV_RESULT_READY;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q  <= DIV_FREE;
                        cnt_q    <= '0;
                        work_q   <= '0;
                        result_q <= '0;
                        ready_q  <= DIV_RESULT_NOT_READY;
                    end else if (cnt_q != DIV_ITERS) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= DIV_RESULT_READY;
                        state_q  <= DIV_END;
                        cnt_q    <= '0;
                    end
                end
                DIV_END: begin
                    // annul is ignored here: EX already owns the result
                    if (start_i == DIV_STOP) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DIV_RESULT_NOT_READY;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q <= DIV_FREE;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Caller is 1 time unit after a rising edge with start_i low; the next edge is E0.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat, input bit scramble,
                           input string name);
        int got;
        int stall_bad;
        got       = 0;
        stall_bad = 0;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        #1;
        n_checks++;
        if (stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall_at_request: actual=%b required=1", name, stallreq_o);
        end
        for (int k = 0; k <= lat + 8; k++) begin
            @(posedge clk); #1;
            if (scramble && k == 3) begin
                opdata1_i    = ~a;
                opdata2_i    = b ^ 32'h5;
                signed_div_i = ~s;
            end
            if (ready_o === 1'b1) begin
                got = k;
                break;
            end
            if (stallreq_o !== 1'b1) stall_bad++;
        end
        n_checks++;
        if (got !== lat) begin
            n_fail++;
            $display("FAIL %s latency: actual=E%0d required=E%0d", name, got, lat);
        end
        n_checks++;
        if (stall_bad !== 0) begin
            n_fail++;
            $display("FAIL %s stall_while_busy: actual=%0d low cycles required=0", name, stall_bad);
        end
        n_checks++;
        if (result_o !== exp) begin
            n_fail++;
            $display("FAIL %s result: actual=%h required=%h", name, result_o, exp);
        end
        n_checks++;
        if (stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_after_ready: actual=%b required=0", name, stallreq_o);
        end
        annul_i = 1'b1;
        for (int h = 1; h <= 5; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b1 || result_o !== exp) begin
                n_fail++;
                $display("FAIL %s hold%0d: actual ready=%b result=%h required ready=1 result=%h",
                         name, h, ready_o, result_o, exp);
            end
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL %s release: actual ready=%b result=%h required ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual ready=%b result=%h stall=%b required 0/0/0",
                     ready_o, result_o, stallreq_o);
        end
        start_i = 1'b1;
        #1;
        n_checks++;
        if (stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_comb: actual=%b required=1", stallreq_o);
        end
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_held: actual ready=%b result=%h required 0/0", ready_o, result_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_unsigned;
        run_div(32'd100,       32'd7,         1'b0, {32'h00000002, 32'h0000000E}, 33, 1'b0, "udiv_100_7");
        run_div(32'h80000000,  32'd3,         1'b0, {32'h00000002, 32'h2AAAAAAA}, 33, 1'b0, "udiv_8000_3");
        run_div(32'hFFFFFFFF,  32'h80000001,  1'b0, {32'h7FFFFFFE, 32'h00000001}, 33, 1'b0, "udiv_big_divisor");
    endtask

    task automatic test_signed;
        run_div(32'hFFFFFFF9, 32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0, "sdiv_m7_2");
        run_div(32'd7,        32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b0, "sdiv_7_m2");
        run_div(32'hFFFFFF9C, 32'd7,         1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0, "sdiv_m100_7");
        run_div(32'hFFFFFFF8, 32'hFFFFFFFD,  1'b1, {32'hFFFFFFFE, 32'h00000002}, 33, 1'b0, "sdiv_m8_m3");
    endtask

    task automatic test_corners;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, 1'b0, "sdiv_min_m1");
        run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h00000001}, 33, 1'b0, "sdiv_m1_m1");
    endtask

    task automatic test_div_zero;
        run_div(32'd123,      32'd0, 1'b0, 64'h0, 1, 1'b0, "udiv_by_zero");
        run_div(32'hFFFFFFFB, 32'd0, 1'b1, 64'h0, 1, 1'b0, "sdiv_by_zero");
    endtask

    task automatic test_annul;
        int rdy_seen;
        rdy_seen     = 0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) rdy_seen++;
            if (k == 10) annul_i = 1'b1;
        end
        n_checks++;
        if (rdy_seen !== 0 || ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_cancel: actual ready_seen=%0d ready=%b result=%h required 0/0/0",
                     rdy_seen, ready_o, result_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        run_div(32'd50, 32'd6, 1'b0, {32'h00000002, 32'h00000008}, 33, 1'b0, "after_annul");
    endtask

    task automatic test_async_reset;
        int got;
        got          = 0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (got !== 1 || result_o !== {32'h00000002, 32'h0000000E}) begin
            n_fail++;
            $display("FAIL rst_end_setup: actual got=%0d result=%h required 1/%h",
                     got, result_o, {32'h00000002, 32'h0000000E});
        end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_async_end: actual ready=%b result=%h required 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        opdata1_i = 32'h12345678;
        opdata2_i = 32'h00001234;
        start_i   = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async_on: actual ready=%b result=%h stall=%b required 0/0/1",
                     ready_o, result_o, stallreq_o);
        end
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_div(32'hFFFFFFFF, 32'h00000010, 1'b0, {32'h0000000F, 32'h0FFFFFFF}, 33, 1'b1, "after_rst_scramble");
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_corners;
        test_div_zero;
        test_annul;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit divide sequencer for DIV/DIVU. The EX stage starts it and holds the operation in EX while it runs. It performs a radix-2 restoring division over 32 iterations and returns {remainder, quotient}. EX forwards that result as the HI/LO pair into the EX/MEM pipeline register. It raises a stall request so the pipeline controller freezes the front of the pipe until the result is ready.

## Interface
- No parameters; operand width fixed at 32 (`RegBus), result 64.
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst==0 resets)
- start_i  in  1  divide request; held high by EX until result consumed
- annul_i  in  1  cancel in-flight divide (branch-delay flush/exception)
- signed_div_i  in  1  1=DIV (signed), 0=DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  out  1  result valid
- stallreq_o  out  1  pipeline stall request, combinational: start_i & ~ready_o

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result held.
- Reset: state=FREE, result_o=0, ready_o=0, cnt=0, internal regs=0.
- FREE:
  - If start_i=1 and annul_i=0: latch operands, cnt<=0.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON.
  - If signed_div_i=1, latch |op| for each negative operand and record both sign bits.
  - start_i with annul_i=1 is ignored (stay FREE).
- ON, each cycle:
  - Partial remainder shifts left one bit and brings in the next dividend bit.
  - Trial subtract the divisor. A non-negative difference replaces the remainder and sets quotient bit 1; otherwise quotient bit 0.
  - cnt increments.
  - After iteration 32 (cnt==32), go to END and register result_o with sign fix-up.
- Signed fix-up:
  - Quotient is negated iff dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0 (two's-complement wrap, no trap).
- BYZERO: next cycle go to END with result_o=0.
- END:
  - ready_o=1; result_o held stable while start_i=1.
  - When start_i=0, go to FREE with ready_o<=0 and result_o<=0.
- annul_i=1 in ON or BYZERO: next edge go to FREE, ready_o=0, result_o=0; partial state discarded.
- annul_i in END: ignored (result already committed to EX).
- Operand inputs are ignored after the start edge; changes mid-operation have no effect.
- A new divide requires start_i to be low for ≥1 cycle after END.

## Timing
- E0 = edge at which start_i is sampled in FREE.
- Nonzero divisor: ON during E1..E32; END entered at E33, so ready_o is high after E33 and stallreq_o falls in the same cycle.
- Divide by zero: BYZERO after E0, END after E1, ready_o high after E1.
- ready_o and result_o are registered; stallreq_o is combinational from start_i and ready_o.
- Asynchronous reset mid-operation: all outputs go to 0 immediately on rst falling; operation resumes from FREE after release.
- Only one divide can be in flight; no queuing.

## Structure
- Shared package (defines.v) carries:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2 bits);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - DIV/DIVU opcodes used by EX to drive signed_div_i.
- One module with the FSM, a 6-bit counter, a 65-bit working register and a 33-bit subtract.
- Optional sub-module div_step: combinational shift/trial-subtract, 33-bit diff out.

## Test plan
- Unsigned 100/7 (signed_div_i=0):
  - ready_o rises after E33;
  - result_o={0x00000002, 0x0000000E};
  - stallreq_o high E0..E33, then low.
- Signed -7/2:
  - q=0xFFFFFFFD, r=0xFFFFFFFF.
  - Signed 7/-2: q=0xFFFFFFFD, r=0x00000001.
- Corners:
  - Signed 0x80000000/0xFFFFFFFF: q=0x80000000, r=0.
  - Unsigned 0x80000000/3: q=0x2AAAAAAA, r=2.
- Divisor 0:
  - ready_o after E1, result_o=0.
  - Hold start_i 5 more cycles: result stable.
  - Drop start_i: FREE, ready_o=0.
- annul_i at E10:
  - FREE after E11, ready_o never rises.
  - A new start at E13 completes normally after E13+33.
- rst pulled low at E20 of an operation:
  - outputs 0 asynchronously;
  - after release, a new divide gives a correct result.
  - Also change opdata1_i/opdata2_i mid-ON: result unaffected.
